// File: rtl/fact_if.sv
// fact_if: host <-> factorial engine handshake bundle.
//   master : host side   (drives go, n, abort; observes status and result)
//   slave  : engine side (observes go, n, abort; drives status and result)
// Signals:
//   go         start request, sampled by the engine only while idle
//   n          operand, latched when go is accepted
//   abort      cancel an in-flight computation
//   busy       engine not idle
//   done       one-cycle completion pulse
//   result     last completed n! mod 2^RESULT_WIDTH
//   overflow   last completed n! did not fit in RESULT_WIDTH bits
//   curr_state raw state encoding, for debug
interface fact_if #(
    parameter int N_WIDTH      = 4,
    parameter int RESULT_WIDTH = 32
);
    logic                    go;
    logic [N_WIDTH-1:0]      n;
    logic                    abort;
    logic                    busy;
    logic                    done;
    logic [RESULT_WIDTH-1:0] result;
    logic                    overflow;
    logic [2:0]              curr_state;

    modport master (
        output go, n, abort,
        input  busy, done, result, overflow, curr_state
    );

    modport slave (
        input  go, n, abort,
        output busy, done, result, overflow, curr_state
    );
endinterface

// File: rtl/fact_engine.sv
// fact_engine: iterative n! engine with a bit-serial shift-add multiplier.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  fact_if slave: go/n/abort in; busy/done/result/overflow/curr_state out
// Each iteration multiplies acc by cnt over N_WIDTH cycles (one operand bit
// per cycle), then decrements cnt. Truncating acc each step keeps the result
// exact modulo 2^RESULT_WIDTH; any bits spilling above that set a sticky flag.
//
// state | meaning
// IDLE  | waiting for go
// CHECK | cnt > 1 ? start another multiply : finish and publish acc
// MUL   | one shift-add step per cycle, bit index 0..N_WIDTH-1
// DEC   | commit product into acc, fold high bits into overflow, cnt--
// DONE  | one-cycle done pulse, back to IDLE
module fact_engine #(
    parameter int N_WIDTH      = 4,
    parameter int RESULT_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    fact_if.slave bus
);
    localparam int IDX_W = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
    localparam int P_W   = RESULT_WIDTH + N_WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_MUL   = 3'd2,
        S_DEC   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [N_WIDTH-1:0]      r_cnt;
    logic [RESULT_WIDTH-1:0] r_acc;
    logic [P_W-1:0]          r_product;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_sticky;
    logic [RESULT_WIDTH-1:0] r_result;
    logic                    r_overflow;

    logic                    w_abort;
    logic [P_W-1:0]          w_addend;

    // abort only counts while a computation is in flight; DONE is final.
    assign w_abort = bus.abort &&
                     (r_state == S_CHECK || r_state == S_MUL || r_state == S_DEC);

    assign w_addend = r_cnt[r_idx] ? (P_W'(r_acc) << r_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.go) w_next_state = S_CHECK;
            S_CHECK: w_next_state = (r_cnt > N_WIDTH'(1)) ? S_MUL : S_DONE;
            S_MUL:   if (r_idx == IDX_LAST) w_next_state = S_DEC;
            S_DEC:   w_next_state = S_CHECK;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (w_abort) w_next_state = S_IDLE;
    end

    // Datapath is frozen on abort so result/overflow keep the last completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_product  <= '0;
            r_idx      <= '0;
            r_sticky   <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (!w_abort) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_cnt    <= bus.n;
                        r_acc    <= RESULT_WIDTH'(1);
                        r_sticky <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (r_cnt > N_WIDTH'(1)) begin
                        r_product <= '0;
                        r_idx     <= '0;
                    end else begin
                        r_result   <= r_acc;
                        r_overflow <= r_sticky;
                    end
                end
                S_MUL: begin
                    r_product <= r_product + w_addend;
                    r_idx     <= r_idx + 1'b1;
                end
                S_DEC: begin
                    r_acc    <= r_product[RESULT_WIDTH-1:0];
                    r_sticky <= r_sticky | (|r_product[P_W-1:RESULT_WIDTH]);
                    r_cnt    <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.result     = r_result;
    assign bus.overflow   = r_overflow;
    assign bus.curr_state = r_state;
endmodule

// File: tb/tb_fact_engine.sv
module tb_fact_engine;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fact_if #(.N_WIDTH(NW), .RESULT_WIDTH(32)) bus32 ();
    fact_if #(.N_WIDTH(NW), .RESULT_WIDTH(8))  bus8 ();

    fact_engine #(.N_WIDTH(NW), .RESULT_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    fact_engine #(.N_WIDTH(NW), .RESULT_WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] f;
        int          c;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    logic [63:0] held32 = '0, held8 = '0;
    logic        hovf32 = 1'b0, hovf8 = 1'b0;

    function automatic logic [63:0] fact(input int k);
        logic [63:0] r = 64'd1;
        for (int i = 2; i <= k; i++) r = r * 64'(i);
        return r;
    endfunction

    function automatic int lat(input int k);
        return (k < 2) ? 2 : 2 + (k - 1) * (NW + 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_done(input string tag, input int rw, input logic [63:0] res,
                              input logic ovf, input exp_t e,
                              output logic [63:0] hres, output logic hovf);
        logic [63:0] m = (64'd1 << rw) - 64'd1;
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(e.c));
        chk({tag, "_result"}, res, e.f & m);
        chk({tag, "_overflow"}, 64'(ovf), 64'(e.f > m));
        hres = e.f & m;
        hovf = (e.f > m);
    endtask

    // Monitors: pop on done, otherwise the published result must hold.
    always @(negedge clk) begin
        if (rst) begin
            held32 = '0;
            hovf32 = 1'b0;
        end else begin
            if (q32.size() > 0 && q32[0].c < cyc) begin
                chk("r32_missing_done", 64'(cyc), 64'(q32[0].c));
                void'(q32.pop_front());
            end
            if (bus32.done) begin
                if (q32.size() == 0) chk("r32_unexpected_done", 64'd1, 64'd0);
                else begin
                    e32 = q32.pop_front();
                    check_done("r32", 32, 64'(bus32.result), bus32.overflow, e32, held32, hovf32);
                end
            end else begin
                chk("r32_hold", {31'd0, bus32.overflow, bus32.result}, {31'd0, hovf32, held32[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            held8 = '0;
            hovf8 = 1'b0;
        end else begin
            if (q8.size() > 0 && q8[0].c < cyc) begin
                chk("r8_missing_done", 64'(cyc), 64'(q8[0].c));
                void'(q8.pop_front());
            end
            if (bus8.done) begin
                if (q8.size() == 0) chk("r8_unexpected_done", 64'd1, 64'd0);
                else begin
                    e8 = q8.pop_front();
                    check_done("r8", 8, 64'(bus8.result), bus8.overflow, e8, held8, hovf8);
                end
            end else begin
                chk("r8_hold", {55'd0, bus8.overflow, bus8.result}, {55'd0, hovf8, held8[7:0]});
            end
        end
    end

    task automatic drive(input logic g, input logic [NW-1:0] nn, input logic ab);
        bus32.go = g; bus32.n = nn; bus32.abort = ab;
        bus8.go  = g; bus8.n  = nn; bus8.abort  = ab;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  64'({bus32.busy, bus8.busy}), 64'd0);
        chk({tag, "_done"},  64'({bus32.done, bus8.done}), 64'd0);
        chk({tag, "_res32"}, 64'(bus32.result), 64'd0);
        chk({tag, "_res8"},  64'(bus8.result), 64'd0);
        chk({tag, "_ovf"},   64'({bus32.overflow, bus8.overflow}), 64'd0);
        chk({tag, "_state"}, 64'({bus32.curr_state, bus8.curr_state}), 64'd0);
    endtask

    // One computation. abort_at < 0: run to completion; otherwise abort is
    // asserted abort_at cycles after the go cycle. hold keeps go high and
    // scrambles n while busy.
    task automatic run(input int k, input int abort_at, input bit hold);
        int c0;
        int l;
        @(negedge clk);
        chk("idle_busy", 64'({bus32.busy, bus8.busy}), 64'd0);
        c0 = cyc;
        l  = lat(k);
        drive(1'b1, NW'(k), 1'b0);
        if (abort_at < 0) begin
            q32.push_back('{f: fact(k), c: c0 + l});
            q8.push_back('{f: fact(k), c: c0 + l});
        end
        for (int d = 1; d <= l; d++) begin
            @(negedge clk);
            if (abort_at >= 0 && d == abort_at + 1) begin
                chk("abort_state", 64'({bus32.curr_state, bus8.curr_state}), 64'd0);
                chk("abort_busy", 64'({bus32.busy, bus8.busy}), 64'd0);
                drive(1'b0, '0, 1'b0);
                break;
            end
            chk("busy", 64'({bus32.busy, bus8.busy}), 64'b11);
            if (k < 2) chk("small_n_state", 64'(bus32.curr_state), (d == 1) ? 64'd1 : 64'd4);
            if (d == abort_at)     drive(hold, NW'($urandom_range(0, 15)), 1'b1);
            else if (hold && d < l) drive(1'b1, NW'($urandom_range(0, 15)), 1'b0);
            else                   drive(1'b0, NW'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int l;
        drive(1'b0, '0, 1'b0);
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        run(5, -1, 1'b0);
        run(0, -1, 1'b0);
        run(1, -1, 1'b0);
        run(12, -1, 1'b0);
        run(13, -1, 1'b0);
        run(15, -1, 1'b0);
        run(4, -1, 1'b0);
        run(7, 4, 1'b0);
        run(3, -1, 1'b0);
        run(6, -1, 1'b1);
        run(2, 1, 1'b0);
        run(0, 1, 1'b1);

        for (int r = 0; r < 40; r++) begin
            k = int'($urandom_range(0, 15));
            l = lat(k);
            if ($urandom_range(0, 4) == 0) run(k, int'($urandom_range(1, l - 1)), 1'($urandom_range(0, 1)));
            else                           run(k, -1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        drive(1'b1, NW'(9), 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_state", 64'(bus32.curr_state), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        #2 rst = 1'b0;

        run(8, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
